// File: rtl/steer_pkg.sv
// Shared types and default constants for the steer-enable controller.
package steer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    STEER_EN = 2'd2
  } steer_state_t;

  localparam int unsigned LD_W_DEF         = 12;
  localparam int unsigned MIN_WT_ON_DEF    = 'h200;
  localparam int unsigned MIN_WT_OFF_DEF   = 'h1C0;
  localparam int unsigned SETTLE_SHFT_DEF  = 2;
  localparam int unsigned STEPOFF_SHFT_DEF = 4;
  localparam int unsigned TMR_W_DEF        = 26;
  localparam int unsigned SETTLE_CNT_DEF   = 'h3DFD240;
  localparam int unsigned FAST_SIM_LIMIT   = 'h3FFF;
  localparam int unsigned OFF_DEB_DEF      = 3;

endpackage

// File: rtl/steer_tmr.sv
// Saturating settle timer: counts every clock up to LIMIT and holds there until cleared.
module steer_tmr
  import steer_pkg::*;
#(
  parameter int unsigned      TMR_W = TMR_W_DEF,
  parameter logic [TMR_W-1:0] LIMIT = TMR_W'(SETTLE_CNT_DEF)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tmr_full
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tmr_full = (cnt_q == LIMIT);

endmodule

// File: rtl/steer_en_gen.sv
// Rider-presence / steer-enable controller: captures load-cell samples, debounces
// step-off and sequences IDLE -> WAIT -> STEER_EN with registered outputs.
module steer_en_gen
  import steer_pkg::*;
#(
  parameter int unsigned LD_W         = LD_W_DEF,
  parameter int unsigned MIN_WT_ON    = MIN_WT_ON_DEF,
  parameter int unsigned MIN_WT_OFF   = MIN_WT_OFF_DEF,
  parameter int unsigned SETTLE_SHFT  = SETTLE_SHFT_DEF,
  parameter int unsigned STEPOFF_SHFT = STEPOFF_SHFT_DEF,
  parameter int unsigned TMR_W        = TMR_W_DEF,
  parameter int unsigned SETTLE_CNT   = SETTLE_CNT_DEF,
  parameter int unsigned FAST_SIM     = 0,
  parameter int unsigned OFF_DEB      = OFF_DEB_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_vld,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  output logic [LD_W:0]   ld_cell_diff,
  output logic            en_steer,
  output logic            rider_off,
  output logic [1:0]      sm_state
);

  localparam logic [TMR_W-1:0] LIMIT = (FAST_SIM != 0) ? TMR_W'(FAST_SIM_LIMIT)
                                                       : TMR_W'(SETTLE_CNT);
  localparam logic [LD_W:0]    WT_ON  = (LD_W+1)'(MIN_WT_ON);
  localparam logic [LD_W:0]    WT_OFF = (LD_W+1)'(MIN_WT_OFF);
  localparam int unsigned      DEB_W  = $clog2(OFF_DEB + 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(OFF_DEB);

  logic [LD_W-1:0]  lft_q, lft_d, rght_q, rght_d;
  logic [LD_W:0]    diff_q, diff_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  steer_state_t     state_q, state_d;
  logic             en_steer_q, en_steer_d;
  logic             rider_off_q, rider_off_d;

  logic [LD_W:0] sum, adiff, in_sum;
  logic          present, unsettled, stepoff, absent_in, off_det;
  logic          clr_tmr, tmr_full;

  // Capture path and debounce counter
  always_comb begin
    lft_d  = lft_q;
    rght_d = rght_q;
    diff_d = diff_q;
    if (ld_vld) begin
      lft_d  = lft_ld;
      rght_d = rght_ld;
      diff_d = {1'b0, lft_ld} - {1'b0, rght_ld};
    end
  end

  // Absent is judged on the incoming sample so the count lands with its capture.
  always_comb begin
    in_sum    = {1'b0, lft_ld} + {1'b0, rght_ld};
    absent_in = (in_sum < WT_OFF);
    deb_d     = deb_q;
    if (state_q == IDLE) begin
      deb_d = '0;
    end else if (ld_vld) begin
      if (!absent_in) begin
        deb_d = '0;
      end else if (deb_q != DEB_MAX) begin
        deb_d = deb_q + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lft_q  <= '0;
      rght_q <= '0;
      diff_q <= '0;
      deb_q  <= '0;
    end else begin
      lft_q  <= lft_d;
      rght_q <= rght_d;
      diff_q <= diff_d;
      deb_q  <= deb_d;
    end
  end

  // Derived flags from the captured sample; magnitude taken without a signed detour.
  always_comb begin
    sum       = {1'b0, lft_q} + {1'b0, rght_q};
    adiff     = (lft_q >= rght_q) ? ({1'b0, lft_q} - {1'b0, rght_q})
                                  : ({1'b0, rght_q} - {1'b0, lft_q});
    present   = (sum > WT_ON);
    unsettled = (adiff > (sum >> SETTLE_SHFT));
    stepoff   = (adiff > (sum - (sum >> STEPOFF_SHFT)));
    off_det   = (deb_q == DEB_MAX);
  end

  steer_tmr #(
    .TMR_W (TMR_W),
    .LIMIT (LIMIT)
  ) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_tmr),
    .tmr_full (tmr_full)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    clr_tmr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (present) begin
          state_d = WAIT;
          clr_tmr = 1'b1;
        end
      end
      WAIT: begin
        if (off_det) begin
          state_d = IDLE;
        end else if (unsettled) begin
          clr_tmr = 1'b1;
        end else if (tmr_full) begin
          state_d = STEER_EN;
        end
      end
      STEER_EN: begin
        if (off_det) begin
          state_d = IDLE;
        end else if (stepoff) begin
          state_d = WAIT;
          clr_tmr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with state entry.
  always_comb begin
    en_steer_d  = (state_d == STEER_EN);
    rider_off_d = (state_q != IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_steer_q  <= 1'b0;
      rider_off_q <= 1'b0;
    end else begin
      en_steer_q  <= en_steer_d;
      rider_off_q <= rider_off_d;
    end
  end

  assign ld_cell_diff = diff_q;
  assign en_steer     = en_steer_q;
  assign rider_off    = rider_off_q;
  assign sm_state     = state_q;

endmodule

// File: tb/tb_steer_en_gen.sv
// Self-checking bench for steer_en_gen: directed phases with randomized samples,
// compared every cycle against an integer reference model of the controller rules.
module tb_steer_en_gen;

  localparam int LIM = 'h3FFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_vld = 1'b0;
  logic [11:0] lft_ld = '0;
  logic [11:0] rght_ld = '0;
  logic [12:0] ld_cell_diff;
  logic        en_steer, rider_off;
  logic [1:0]  sm_state;

  int n_pass = 0;
  int n_total = 0;
  int n_off = 0;
  int en_at_off = 0;

  // reference model state: 0 idle, 1 waiting to settle, 2 steering
  int m_state = 0, m_tmr = 0, m_cnt = 0, m_l = 0, m_r = 0, m_diff = 0, m_en = 0, m_off = 0;

  always #5 clk = ~clk;

  steer_en_gen #(
    .LD_W         (12),
    .MIN_WT_ON    ('h200),
    .MIN_WT_OFF   ('h1C0),
    .SETTLE_SHFT  (2),
    .STEPOFF_SHFT (4),
    .TMR_W        (26),
    .SETTLE_CNT   ('h3DFD240),
    .FAST_SIM     (1),
    .OFF_DEB      (3)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .ld_vld       (ld_vld),
    .lft_ld       (lft_ld),
    .rght_ld      (rght_ld),
    .ld_cell_diff (ld_cell_diff),
    .en_steer     (en_steer),
    .rider_off    (rider_off),
    .sm_state     (sm_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_step();
    int sum, ad, ns, in_sum;
    bit present, unsettled, stepoff, off_det, full, clr;
    if (rst) begin
      m_state = 0; m_tmr = 0; m_cnt = 0; m_l = 0; m_r = 0;
      m_diff = 0; m_en = 0; m_off = 0;
      return;
    end
    sum       = m_l + m_r;
    ad        = (m_l > m_r) ? m_l - m_r : m_r - m_l;
    present   = sum > 'h200;
    unsettled = ad > sum / 4;
    stepoff   = ad > sum - sum / 16;
    off_det   = (m_cnt == 3);
    full      = (m_tmr == LIM);
    ns  = m_state;
    clr = 0;
    case (m_state)
      0: if (present) begin ns = 1; clr = 1; end
      1: if (off_det) ns = 0;
         else if (unsettled) clr = 1;
         else if (full) ns = 2;
      default: if (off_det) ns = 0;
               else if (stepoff) begin ns = 1; clr = 1; end
    endcase
    m_tmr = clr ? 0 : ((m_tmr < LIM) ? m_tmr + 1 : LIM);
    in_sum = int'(lft_ld) + int'(rght_ld);
    if (m_state == 0) m_cnt = 0;
    else if (ld_vld) m_cnt = (in_sum < 'h1C0) ? ((m_cnt < 3) ? m_cnt + 1 : 3) : 0;
    if (ld_vld) begin
      m_l = int'(lft_ld);
      m_r = int'(rght_ld);
      m_diff = m_l - m_r;
    end
    m_off   = (m_state != 0 && ns == 0) ? 1 : 0;
    m_en    = (ns == 2) ? 1 : 0;
    m_state = ns;
  endtask

  task automatic tick(input logic rs, input logic v, input int l, input int r);
    @(negedge clk);
    rst = rs; ld_vld = v; lft_ld = 12'(l); rght_ld = 12'(r);
    @(posedge clk);
    model_step();
    #1;
    chk("sm_state", 32'(sm_state), 32'(m_state));
    chk("en_steer", 32'(en_steer), 32'(m_en));
    chk("rider_off", 32'(rider_off), 32'(m_off));
    chk("ld_cell_diff", 32'(ld_cell_diff), 32'(m_diff) & 32'h1FFF);
    if (rider_off === 1'b1) begin
      n_off++;
      en_at_off = int'(en_steer);
    end
  endtask

  task automatic run(input int n, input int l, input int r, input int noise, input int period);
    for (int i = 0; i < n; i++)
      tick(1'b0, (i % period) == 0, l + $urandom_range(0, noise), r + $urandom_range(0, noise));
  endtask

  task automatic run_until_en(input int l, input int r, input int noise, input int period,
                              input int max, output int cyc);
    cyc = 0;
    while (cyc < max && en_steer !== 1'b1) begin
      tick(1'b0, (cyc % period) == 0, l + $urandom_range(0, noise), r + $urandom_range(0, noise));
      cyc++;
    end
  endtask

  initial begin
    int cyc, off0, kind, l, r;

    // reset
    tick(1'b1, 1'b0, 0, 0);
    tick(1'b1, 1'b0, 0, 0);
    chk("reset_state", 32'(sm_state), 0);
    chk("reset_en", 32'(en_steer), 0);
    chk("reset_diff", 32'(ld_cell_diff), 0);

    // enable with balanced load
    tick(1'b0, 1'b1, 'h180, 'h180);
    tick(1'b0, 1'b0, 'h180, 'h180);
    chk("wait_after_capture", 32'(sm_state), 1);
    run_until_en('h180, 'h180, 'h10, 8, 2 * LIM, cyc);
    chk("settle_time_window", 32'(cyc >= LIM - 1 && cyc <= LIM + 3), 1);
    chk("en_after_settle", 32'(en_steer), 1);
    chk("no_rider_off_enable", 32'(n_off), 0);

    // step-off drops back to WAIT without rider_off
    tick(1'b0, 1'b1, 'h3F0, 'h008);
    tick(1'b0, 1'b0, 'h3F0, 'h008);
    chk("stepoff_to_wait", 32'(sm_state), 1);
    chk("stepoff_en_low", 32'(en_steer), 0);
    chk("stepoff_no_rider_off", 32'(n_off), 0);

    // unsettled load keeps timer cleared, then balanced load re-enables
    run(2 * LIM, 'h300, 'h080, 'h10, 8);
    chk("unsettled_en_low", 32'(en_steer), 0);
    run_until_en('h180, 'h180, 'h10, 8, 2 * LIM, cyc);
    chk("resettle_window", 32'(cyc >= LIM && cyc <= LIM + 4), 1);
    chk("resettle_en", 32'(en_steer), 1);

    // debounce: two absent samples then present keeps steering
    run(8, 'h80, 'h80, 'h8, 8);
    run(8, 'h80, 'h80, 'h8, 8);
    run(8, 'h180, 'h180, 'h8, 8);
    chk("debounce_hold", 32'(sm_state), 2);
    off0 = n_off;
    run(8, 'h80, 'h80, 'h8, 8);
    run(8, 'h80, 'h80, 'h8, 8);
    run(8, 'h80, 'h80, 'h8, 8);
    run(16, 'h80, 'h80, 'h8, 8);
    chk("debounce_idle", 32'(sm_state), 0);
    chk("rider_off_one_pulse", 32'(n_off - off0), 1);
    chk("en_low_at_rider_off", 32'(en_at_off), 0);

    // hysteresis band in IDLE, full-scale sample, then band in WAIT
    run(24, 'hF0, 'hF0, 0, 8);
    chk("band_stays_idle", 32'(sm_state), 0);
    tick(1'b0, 1'b1, 'hFFF, 'hFFF);
    chk("fullscale_diff", 32'(ld_cell_diff), 0);
    tick(1'b0, 1'b0, 'hFFF, 'hFFF);
    chk("fullscale_present", 32'(sm_state), 1);
    off0 = n_off;
    run_until_en('hF0, 'hF0, 'h8, 8, 2 * LIM, cyc);
    chk("band_wait_reaches_en", 32'(en_steer), 1);
    chk("band_no_rider_off", 32'(n_off - off0), 0);

    // reset mid-run
    tick(1'b1, 1'b0, 'h180, 'h180);
    chk("midrst_state", 32'(sm_state), 0);
    chk("midrst_en", 32'(en_steer), 0);
    chk("midrst_off", 32'(rider_off), 0);
    chk("midrst_diff", 32'(ld_cell_diff), 0);
    chk("midrst_tmr", 32'(u_dut.u_tmr.cnt_q), 0);

    // mixed random samples
    for (int i = 0; i < 3000; i++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin l = 'h180 + $urandom_range(0, 'h20); r = 'h180 + $urandom_range(0, 'h20); end
        1: begin l = 'h70 + $urandom_range(0, 'h20); r = 'h70 + $urandom_range(0, 'h20); end
        2: begin l = 'h300; r = 'h080; end
        3: begin l = 'h3F0; r = 'h008; end
        default: begin l = $urandom_range(0, 'hFFF); r = $urandom_range(0, 'hFFF); end
      endcase
      tick(1'b0, $urandom_range(0, 3) == 0, l, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
